// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake between a host and clk_div_ctrl.
// The host offers cfg_div with cfg_valid; the controller answers with cfg_ready.
interface clk_div_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 cfg_valid;
    logic [CNT_WIDTH-1:0] cfg_div;
    logic                 cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: clk_out has a half-period of div_active clk_in cycles,
// with glitch-free divisor changes and a clean stop that always parks clk_out low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | clk_out held 0, counter 0, divisor writes take effect at once
// RUN   | counting; clk_out toggles at terminal count
// STOP  | run dropped while clk_out high; finish the high phase, then IDLE
module clk_div_ctrl #(
    parameter int CNT_WIDTH   = 32,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 run_en,
    input  logic                 err_clr,
    clk_div_ctrl_if.slave        cfg,
    output logic                 clk_out,
    output logic [CNT_WIDTH-1:0] div_active,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    state_t               state,       state_nxt;
    logic [CNT_WIDTH-1:0] counter,     counter_nxt;
    logic                 clk_out_nxt;
    logic [CNT_WIDTH-1:0] div_nxt;
    logic [CNT_WIDTH-1:0] pend_div,    pend_div_nxt;
    logic                 pend_valid,  pend_valid_nxt;
    logic                 err_nxt;

    logic                 xfer;
    logic                 xfer_ok;
    logic                 xfer_zero;
    logic                 tc;
    logic [CNT_WIDTH-1:0] div_settle;

    assign xfer      = cfg.cfg_valid && !pend_valid;
    assign xfer_ok   = xfer && (cfg.cfg_div != '0);
    assign xfer_zero = xfer && (cfg.cfg_div == '0);
    assign tc        = (counter == (div_active - ONE));

    // Divisor to carry into IDLE: a same-edge offer wins, else any pending one.
    assign div_settle = xfer_ok    ? cfg.cfg_div :
                        pend_valid ? pend_div    : div_active;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            clk_out    <= 1'b0;
            div_active <= DIV_RST;
            pend_div   <= '0;
            pend_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            counter    <= counter_nxt;
            clk_out    <= clk_out_nxt;
            div_active <= div_nxt;
            pend_div   <= pend_div_nxt;
            pend_valid <= pend_valid_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        counter_nxt    = counter;
        clk_out_nxt    = clk_out;
        div_nxt        = div_active;
        pend_div_nxt   = pend_div;
        pend_valid_nxt = pend_valid;
        err_nxt        = err;

        // A new zero-divisor error outranks a clear on the same edge.
        if (xfer_zero) begin
            err_nxt = 1'b1;
        end else if (err_clr) begin
            err_nxt = 1'b0;
        end

        if (xfer_ok && (state != IDLE)) begin
            pend_div_nxt   = cfg.cfg_div;
            pend_valid_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                counter_nxt = '0;
                clk_out_nxt = 1'b0;
                if (xfer_ok) begin
                    div_nxt = cfg.cfg_div;
                end
                if (run_en) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (!run_en && !clk_out) begin
                    // Low phase: stop immediately, even at terminal count.
                    state_nxt      = IDLE;
                    counter_nxt    = '0;
                    div_nxt        = div_settle;
                    pend_valid_nxt = 1'b0;
                end else begin
                    if (tc) begin
                        counter_nxt = '0;
                        clk_out_nxt = !clk_out;
                        // Swap divisors only on the falling toggle so no half-period is cut.
                        if (clk_out && pend_valid) begin
                            div_nxt        = pend_div;
                            pend_valid_nxt = 1'b0;
                        end
                    end else begin
                        counter_nxt = counter + ONE;
                    end
                    if (!run_en) begin
                        if (tc) begin
                            state_nxt      = IDLE;
                            div_nxt        = div_settle;
                            pend_valid_nxt = 1'b0;
                        end else begin
                            state_nxt = STOP;
                        end
                    end
                end
            end

            STOP: begin
                if (tc) begin
                    state_nxt      = IDLE;
                    counter_nxt    = '0;
                    clk_out_nxt    = 1'b0;
                    div_nxt        = div_settle;
                    pend_valid_nxt = 1'b0;
                end else begin
                    counter_nxt = counter + ONE;
                end
            end

            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
                clk_out_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy          = pend_valid;
        cfg.cfg_ready = !pend_valid;
    end

endmodule
